// File: rtl/dbg_cmd_pkg.sv
// Shared definitions for the debug command sequencer.
//   state_t            : one-hot FSM encoding used by dbg_cmd_sequencer
//   DEFAULT_CMD_ADDR   : default address whose write issues a req/ack command
//   RSP_* bit indices  : response entry layout {data, is_read, timeout}
//   rsp_width()        : response entry width for a given data width
package dbg_cmd_pkg;

  typedef enum logic [3:0] {
    STATE_IDLE  = 4'b0001,
    STATE_SETUP = 4'b0010,
    STATE_READ  = 4'b0100,
    STATE_ISSUE = 4'b1000
  } state_t;

  localparam int DEFAULT_CMD_ADDR = 0;

  // Response entry: data occupies the top DATA_WIDTH bits, flags sit below it.
  localparam int RSP_TIMEOUT_BIT = 0;
  localparam int RSP_IS_READ_BIT = 1;
  localparam int RSP_DATA_LSB    = 2;

  function automatic int rsp_width(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/dbg_cmd_sequencer_fifo.sv
// dbg_rsp_fifo: synchronous show-ahead FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write side (ignored when full unless a pop frees a slot)
//   pop, pop_data   : read side; pop_data always shows the head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries (clog2(DEPTH)+1 bits)
// DEPTH must be a power of two so the pointers wrap naturally.
module dbg_rsp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dbg_cmd_sequencer.sv
// dbg_cmd_sequencer: debug-port master. Sequences host commands onto the CPU
// debug slave bus and returns results on a buffered response stream.
//   clk, rst                         : clock, synchronous active-high reset
//   cmd_valid/ready/rnw/addr/wdata   : host command stream
//   rsp_valid/ready/data/is_read/timeout : host response stream (show-ahead)
//   addr, write_data, wr_en          : debug register write bus
//   read_data                        : debug register read bus
//   req, ack                         : command handshake to the debug slave
//   busy                             : a command is in flight
//
// state  | meaning
// IDLE   | waiting for a command; accepts when response space and no stale ack
// SETUP  | bus driven with latched command; write strobe for writes
// READ   | capture read_data into a response
// ISSUE  | req held until ack or timeout
module dbg_cmd_sequencer
  import dbg_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_ADDR       = DEFAULT_CMD_ADDR,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WRITE_RSP      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_is_read,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  wr_en,
  output logic                  req,
  input  logic                  ack,
  output logic                  busy
);

  localparam int RW  = DATA_WIDTH + 2;
  localparam int FCW = $clog2(RSP_DEPTH) + 1;
  localparam int CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0]         TO_LAST  = TO_LAST_I[CW-1:0];
  localparam logic [ADDR_WIDTH-1:0] CMD_A    = CMD_ADDR[ADDR_WIDTH-1:0];
  localparam logic [FCW-1:0]        CNT_FULL = RSP_DEPTH[FCW-1:0];

  state_t                 state;
  state_t                 state_nxt;
  logic                   lat_rnw;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0]  lat_wdata;
  logic [CW-1:0]          to_cnt;
  logic                   accept;
  logic                   timed_out;
  logic                   push;
  logic [RW-1:0]          push_data;
  logic [RW-1:0]          head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FCW-1:0]         fifo_count;

  assign accept     = cmd_valid && cmd_ready;
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST) && !ack;
  assign addr       = lat_addr;
  assign write_data = lat_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= STATE_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      STATE_IDLE:  if (accept) state_nxt = STATE_SETUP;
      STATE_SETUP: begin
        if (lat_rnw)               state_nxt = STATE_READ;
        else if (lat_addr == CMD_A) state_nxt = STATE_ISSUE;
        else                       state_nxt = STATE_IDLE;
      end
      STATE_READ:  state_nxt = STATE_IDLE;
      STATE_ISSUE: if (ack || timed_out) state_nxt = STATE_IDLE;
      default:     state_nxt = STATE_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = 1'b0;
    wr_en     = 1'b0;
    req       = 1'b0;
    push      = 1'b0;
    push_data = '0;
    busy      = (state != STATE_IDLE);
    case (state)
      STATE_IDLE: cmd_ready = !fifo_full && !ack;
      STATE_SETUP: begin
        wr_en = !lat_rnw;
        if (!lat_rnw && (lat_addr != CMD_A) && (WRITE_RSP != 0)) push = 1'b1;
      end
      STATE_READ: begin
        push      = 1'b1;
        push_data = {read_data, 1'b1, 1'b0};
      end
      STATE_ISSUE: begin
        req = !ack;
        // ack takes priority over a timeout landing in the same cycle
        if (ack) begin
          push = 1'b1;
        end else if (timed_out) begin
          push      = 1'b1;
          push_data = {{DATA_WIDTH{1'b0}}, 1'b0, 1'b1};
        end
      end
      default: ;
    endcase
  end

  // Command latch and ISSUE cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_rnw   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      to_cnt    <= '0;
    end else begin
      if (accept) begin
        lat_rnw   <= cmd_rnw;
        lat_addr  <= cmd_addr;
        lat_wdata <= cmd_wdata;
      end
      if (state == STATE_ISSUE) begin
        if (ack || timed_out) to_cnt <= '0;
        else                  to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  dbg_rsp_fifo #(
    .WIDTH (RW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_valid && rsp_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid   = !fifo_empty;
  assign rsp_data    = head[RW-1:RSP_DATA_LSB];
  assign rsp_is_read = head[RSP_IS_READ_BIT];
  assign rsp_timeout = head[RSP_TIMEOUT_BIT];

  // Acceptance is gated on space and only the in-flight command pushes,
  // so a push never meets a full FIFO.
  push_has_space: assert property (@(posedge clk) disable iff (rst)
    push |-> (fifo_count != CNT_FULL));

endmodule

// File: tb/tb_dbg_cmd_sequencer.sv
module tb_dbg_cmd_sequencer;

  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int CMDA  = 0;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rnw = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_is_read;
  logic          rsp_timeout;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data = '0;
  logic          wr_en;
  logic          req;
  logic          ack = 1'b0;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int req_cnt = 0;
  logic [DW+1:0] exp_q[$];

  always #5 clk = ~clk;

  dbg_cmd_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_ADDR(CMDA), .RSP_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO), .WRITE_RSP(1)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_is_read(rsp_is_read), .rsp_timeout(rsp_timeout),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .wr_en(wr_en), .req(req), .ack(ack), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response a command must produce, from its meaning alone.
  function automatic logic [DW+1:0] model_rsp(input logic rnw, input logic [AW-1:0] a,
                                              input logic [DW-1:0] slave_data,
                                              input logic acked);
    if (rnw)           return {slave_data, 1'b1, 1'b0};
    else if (a == CMDA) return {{DW{1'b0}}, 1'b0, !acked};
    else               return {{DW{1'b0}}, 1'b0, 1'b0};
  endfunction

  // Compare process: head of the response stream against the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) wr_cnt++;
      if (req)   req_cnt++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          chk("rsp_head", 64'({rsp_data, rsp_is_read, rsp_timeout}), 64'(exp_q[0]));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    cmd_rnw   = rnw;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int n;
    // reset state
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_wr_en",     64'(wr_en),     64'd0);
    chk("rst_req",       64'(req),       64'd0);
    chk("rst_busy",      64'(busy),      64'd0);

    // read addr 2: response three cycles after accept
    read_data = 32'hdeadbeef;
    exp_q.push_back(model_rsp(1'b1, 2'd2, 32'hdeadbeef, 1'b1));
    wr_cnt = 0; req_cnt = 0;
    send_cmd(1'b1, 2'd2, 32'h0);
    chk("rd_busy", 64'(busy), 64'd1);
    tick();
    chk("rd_valid_early", 64'(rsp_valid), 64'd0);
    tick();
    chk("rd_valid", 64'(rsp_valid), 64'd1);
    chk("rd_data", 64'(rsp_data), 64'hdeadbeef);
    chk("rd_is_read", 64'(rsp_is_read), 64'd1);
    chk("rd_timeout", 64'(rsp_timeout), 64'd0);
    tick();
    chk("rd_drained", 64'(rsp_valid), 64'd0);
    chk("rd_no_wr_en", 64'(wr_cnt), 64'd0);
    chk("rd_no_req", 64'(req_cnt), 64'd0);

    // plain write addr 1
    exp_q.push_back(model_rsp(1'b0, 2'd1, '0, 1'b1));
    wr_cnt = 0; req_cnt = 0;
    send_cmd(1'b0, 2'd1, 32'h1234);
    chk("wr_en", 64'(wr_en), 64'd1);
    chk("wr_addr", 64'(addr), 64'd1);
    chk("wr_data", 64'(write_data), 64'h1234);
    tick();
    chk("wr_en_drop", 64'(wr_en), 64'd0);
    chk("wr_busy", 64'(busy), 64'd0);
    chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_rsp_lit", 64'({rsp_data, rsp_is_read, rsp_timeout}), 64'd0);
    tick();
    chk("wr_strobe_cycles", 64'(wr_cnt), 64'd1);
    chk("wr_no_req", 64'(req_cnt), 64'd0);

    // command write, ack after 5 req cycles
    exp_q.push_back(model_rsp(1'b0, 2'd0, '0, 1'b1));
    req_cnt = 0;
    send_cmd(1'b0, 2'd0, 32'hAA);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("cmd_req_high", 64'(req), 64'd1);
      tick();
    end
    ack = 1'b1;
    #1;
    chk("cmd_req_ack_cycle", 64'(req), 64'd0);
    tick();
    ack = 1'b0;
    #1;
    chk("cmd_ready_after_ack", 64'(cmd_ready), 64'd1);
    chk("cmd_busy", 64'(busy), 64'd0);
    chk("cmd_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("cmd_req_cycles", 64'(req_cnt), 64'd5);
    tick();

    // command write, no ack: timeout after TO req cycles
    exp_q.push_back(model_rsp(1'b0, 2'd0, '0, 1'b0));
    req_cnt = 0;
    send_cmd(1'b0, 2'd0, 32'h55);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 40);
    chk("to_finished", 64'(busy), 64'd0);
    chk("to_req_cycles", 64'(req_cnt), 64'(TO));
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_flag", 64'(rsp_timeout), 64'd1);
    tick();

    // ack on the final timeout cycle wins
    exp_q.push_back(model_rsp(1'b0, 2'd0, '0, 1'b1));
    req_cnt = 0;
    send_cmd(1'b0, 2'd0, 32'h66);
    tick();
    repeat (TO - 1) tick();
    chk("to8_busy", 64'(busy), 64'd1);
    ack = 1'b1;
    #1;
    chk("to8_req_drop", 64'(req), 64'd0);
    tick();
    ack = 1'b0;
    #1;
    chk("to8_busy_done", 64'(busy), 64'd0);
    chk("to8_flag", 64'(rsp_timeout), 64'd0);
    chk("to8_req_cycles", 64'(req_cnt), 64'(TO - 1));
    tick();

    // fill the response FIFO with rsp_ready low
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      read_data = 32'h100 + 32'(i);
      exp_q.push_back(model_rsp(1'b1, 2'(i), 32'h100 + 32'(i), 1'b1));
      send_cmd(1'b1, 2'(i), '0);
      tick();
      tick();
    end
    chk("full_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("full_head", 64'(rsp_data), 64'h100);
    read_data = 32'h200;
    exp_q.push_back(model_rsp(1'b1, 2'd3, 32'h200, 1'b1));
    cmd_rnw = 1'b1; cmd_addr = 2'd3; cmd_wdata = '0; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_stall", 64'(cmd_ready), 64'd0);
      tick();
    end
    chk("full_idle", 64'(busy), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("full_space_ready", 64'(cmd_ready), 64'd1);
    chk("full_new_head", 64'(rsp_data), 64'h101);
    send_cmd(1'b1, 2'd3, '0);
    tick();
    tick();
    rsp_ready = 1'b1;
    n = 0;
    while (rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("full_drained", 64'(rsp_valid), 64'd0);
    chk("model_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset while a command is in ISSUE
    send_cmd(1'b0, 2'd0, 32'h77);
    tick();
    tick();
    chk("mid_req", 64'(req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_req_drop", 64'(req), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);
    ack = 1'b1;
    #1;
    chk("stale_ack_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk("stale_ack_hold", 64'(cmd_ready), 64'd0);
    chk("stale_ack_idle", 64'(busy), 64'd0);
    ack = 1'b0;
    #1;
    chk("ack_drop_ready", 64'(cmd_ready), 64'd1);
    tick();
    tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
